// File: rtl/npu_sched_pkg.sv
// Shared scheduler definitions: FSM state encoding, default burst-length
// field width and the one-hot to binary index encoder.
package npu_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  localparam int DEF_LEN_W  = 4;

  // Widest one-hot vector the encoder accepts (caps the requester count)
  localparam int ONEHOT_MAX = 64;

  // Returns the index of the set bit of a one-hot vector (0 when empty)
  function automatic logic [31:0] onehot_to_bin(input logic [ONEHOT_MAX-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      if (oh[i]) begin
        idx = idx | 32'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_burst_scheduler_pick.sv
// rr_pick_onehot: stateless round-robin picker. Prefers the lowest requester
// inside the pointer mask, falls back to the lowest requester overall, and
// returns the mask of ports strictly above the pick for the next round.
module rr_pick_onehot #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] pointer,
  output logic [N-1:0] pick,
  output logic [N-1:0] next_mask
);

  logic [N-1:0] masked;
  logic [N-1:0] source;
  logic [N-1:0] upto_pick;

  assign masked = req & pointer;
  assign source = (|masked) ? masked : req;

  // Isolate the lowest set bit of the chosen request set
  assign pick = source & (~source + N'(1));

  // Bits 0..w set for pick at w; shifting the top port out leaves all ones,
  // so the resulting mask is empty and the next pick falls back to the lowest
  assign upto_pick = (pick << 1) - N'(1);
  assign next_mask = ~upto_pick;

endmodule

// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler: shares one multi-beat port among REQ_WIDTH requesters.
// A round-robin winner keeps its grant for the whole burst; the port is freed
// after the last acknowledged beat, with one idle cycle before the next grant.
// Optional feature macro RR_SCHED_STARVE_EN adds per-port wait counters that
// let a port that lost STARVE_LIMIT arbitrations override round-robin.
module rr_burst_scheduler
  import npu_sched_pkg::*;
#(
  parameter int REQ_WIDTH    = 16,
  parameter int LEN_W        = DEF_LEN_W
`ifdef RR_SCHED_STARVE_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_WIDTH-1:0]         req_valid,
  input  logic [REQ_WIDTH*LEN_W-1:0]   req_len,
  input  logic                         beat_ack,
  output logic [REQ_WIDTH-1:0]         gnt,
  output logic [$clog2(REQ_WIDTH)-1:0] gnt_port,
  output logic                         busy,
  output logic                         burst_done
);

  localparam int PORT_W = $clog2(REQ_WIDTH);

  sched_state_e         state;
  logic [REQ_WIDTH-1:0] pointer;
  logic [LEN_W-1:0]     beat_cnt;

  logic                 any_req;
  logic [REQ_WIDTH-1:0] rr_pick;
  logic [REQ_WIDTH-1:0] rr_mask;
  logic [REQ_WIDTH-1:0] win_oh;
  logic [REQ_WIDTH-1:0] win_mask;
  logic [PORT_W-1:0]    win_idx;
  logic [LEN_W-1:0]     win_len;

  assign any_req = |req_valid;

  rr_pick_onehot #(
    .N(REQ_WIDTH)
  ) u_rr_pick (
    .req       (req_valid),
    .pointer   (pointer),
    .pick      (rr_pick),
    .next_mask (rr_mask)
  );

`ifdef RR_SCHED_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]     wait_cnt [REQ_WIDTH];
  logic [REQ_WIDTH-1:0] starve_req;
  logic [REQ_WIDTH-1:0] starve_pick;
  logic [REQ_WIDTH-1:0] starve_mask;

  // Flag requesting ports whose loss count reached the starvation threshold
  always_comb begin
    starve_req = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      starve_req[i] = req_valid[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT));
    end
  end

  // An empty pointer makes the picker return the lowest starving port
  rr_pick_onehot #(
    .N(REQ_WIDTH)
  ) u_starve_pick (
    .req       (starve_req),
    .pointer   ({REQ_WIDTH{1'b0}}),
    .pick      (starve_pick),
    .next_mask (starve_mask)
  );

  assign win_oh   = (|starve_req) ? starve_pick : rr_pick;
  assign win_mask = (|starve_req) ? starve_mask : rr_mask;

  // Count lost idle arbitrations per port; a grant or dropped request clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        if (!req_valid[i]) begin
          wait_cnt[i] <= '0;
        end else if (state == IDLE && any_req) begin
          if (win_oh[i]) begin
            wait_cnt[i] <= '0;
          end else if (wait_cnt[i] != {CNT_W{1'b1}}) begin
            wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end
`else
  assign win_oh   = rr_pick;
  assign win_mask = rr_mask;
`endif

  assign win_idx = PORT_W'(onehot_to_bin(ONEHOT_MAX'(win_oh)));

  // Select the burst length field of the winning port
  always_comb begin
    win_len = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (win_oh[i]) begin
        win_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Arbitrate while idle, then count accepted beats until the burst ends
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pointer    <= '1;
      beat_cnt   <= '0;
      gnt        <= '0;
      gnt_port   <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= BUSY;
            gnt      <= win_oh;
            gnt_port <= win_idx;
            busy     <= 1'b1;
            beat_cnt <= win_len;
            pointer  <= win_mask;
          end
        end
        BUSY: begin
          if (beat_ack) begin
            if (beat_cnt == '0) begin
              state      <= IDLE;
              gnt        <= '0;
              gnt_port   <= '0;
              busy       <= 1'b0;
              burst_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - LEN_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
